// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: exception, stall-held redirect, eret/branch and sequential stepping.
// Define PC_FETCH_CHECK_EN to flag misaligned or out-of-range fetch addresses on fetch_exc.
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC    = 32'h0000_4180,
    parameter int               STEP       = 4,
    parameter logic [WIDTH-1:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IMEM_LIMIT = 32'h0000_6FFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] target_pc,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             exc_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pend_valid,
    output logic             fetch_exc,
    output logic [15:0]      stall_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q = RESET_VEC;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    assign pc_plus = pc_q + WIDTH'(STEP);

    // Priority: exc_req > stall > pending > eret > redirect > sequential.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        stall_cnt_d = stall_cnt_q;

        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        if (exc_req) begin
            pc_d    = EXC_VEC;
            state_d = RUN;
            pend_d  = '0;
        end else if (stall) begin
            // Only the first redirect seen during a stall is remembered.
            if ((state_q == RUN) && (eret || redirect)) begin
                pend_d  = eret ? epc : target_pc;
                state_d = HELD;
            end
        end else if (state_q == HELD) begin
            pc_d    = pend_q;
            state_d = RUN;
        end else if (eret) begin
            pc_d = epc;
        end else if (redirect) begin
            pc_d = target_pc;
        end else begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_VEC;
            pend_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc         = pc_q;
    assign pend_valid = (state_q == HELD);
    assign stall_cnt  = stall_cnt_q;

`ifdef PC_FETCH_CHECK_EN
    assign fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q > IMEM_LIMIT);
`else
    logic unused_imem_cfg;
    assign unused_imem_cfg = ^{IMEM_BASE, IMEM_LIMIT};
    assign fetch_exc = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
- REQ-001 SHALL provide parameter WIDTH, default 32, PC/address width in bits.
- REQ-002 SHALL provide parameter RESET_VEC, default 32'h0000_3000, PC value after reset.
- REQ-003 SHALL provide parameter EXC_VEC, default 32'h0000_4180, exception/interrupt entry address.
- REQ-004 SHALL provide parameter STEP, default 4, sequential increment.
- REQ-005 SHALL provide parameters IMEM_BASE, default 32'h0000_3000, and IMEM_LIMIT, default 32'h0000_6FFF, the inclusive legal fetch range.
- REQ-006 SHALL provide ports:
  clk  in  1  clock; single clock domain, all state on rising edge
  reset  in  1  synchronous, active-high reset
  stall  in  1  front-end hold; PC must not advance
  redirect  in  1  branch/jump taken; target on target_pc
  target_pc  in  WIDTH  branch/jump target
  eret  in  1  exception return; target on epc
  epc  in  WIDTH  return address from CP0
  exc_req  in  1  interrupt or exception request (IntReq|ExcReq)
  pc  out  WIDTH  current fetch address (registered)
  pc_plus  out  WIDTH  pc+STEP, combinational, modulo 2^WIDTH
  pend_valid  out  1  a redirect is held awaiting stall release
  fetch_exc  out  1  current pc is an illegal fetch address
  stall_cnt  out  16  saturating count of stalled cycles since reset

Function
- REQ-007 SHALL evaluate per cycle in strict priority: reset > exc_req > stall > pending > eret > redirect > sequential.
- REQ-008 exc_req SHALL load pc<=EXC_VEC next edge regardless of stall, eret, redirect or pending, and SHALL clear pend_valid.
- REQ-009 With stall=1 and no exc_req, pc SHALL hold its value.
- REQ-010 Two states: RUN (pend_valid=0), HELD (pend_valid=1); pend_valid SHALL equal state==HELD.
- REQ-011 RUN, stall=1, eret or redirect asserted: SHALL capture target (epc if eret, else target_pc) into pending register, go HELD next edge.
- REQ-012 HELD, stall=1: further eret/redirect SHALL be ignored; first-captured target kept.
- REQ-013 HELD, stall=0: SHALL load pc<=pending target, return to RUN; eret/redirect asserted that cycle SHALL be discarded.
- REQ-014 RUN, stall=0: eret SHALL load pc<=epc; else redirect SHALL load pc<=target_pc; else pc<=pc+STEP.
- REQ-015 Redirect latency SHALL be one edge: target visible on pc the cycle after request accepted.
- REQ-016 pc+STEP SHALL wrap modulo 2^WIDTH (0xFFFF_FFFC+4 -> 0x0000_0000).
- REQ-017 stall_cnt SHALL increment on every edge with stall=1 and reset=0, saturating at 16'hFFFF.

Reset
- REQ-018 reset=1 at edge SHALL set pc=RESET_VEC, state=RUN, pending register=0, stall_cnt=0; overrides all other inputs.
- REQ-019 Reset mid-HELD SHALL drop the pending target; no redirect applied after reset release.
- REQ-020 pc SHALL also initialise to RESET_VEC at time zero for simulation.

Configuration
- REQ-021 Macro PC_FETCH_CHECK_EN SHALL gate fetch checking.
- REQ-022 Defined: fetch_exc=1 (combinational from pc) when pc[1:0]!=0, pc<IMEM_BASE or pc>IMEM_LIMIT; else 0.
- REQ-023 Undefined: fetch_exc SHALL be constant 0; no comparator logic synthesised; all other behaviour identical.

Verification
- REQ-024 Reset then 3 free-running cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; stall_cnt=0.
- REQ-025 pc=0x3010, stall=1 with redirect target_pc=0x3400 for 1 cycle, stall held 3 cycles -> pc stays 0x3010, pend_valid=1, stall_cnt=3; stall=0 -> pc=0x3400 next edge, pend_valid=0.
- REQ-026 HELD with target 0x3400, exc_req=1 while stall=1 -> pc=0x4180, pend_valid=0; after stall release pc=0x4184 (target discarded).
- REQ-027 RUN, eret=1 epc=0x3020 and redirect=1 target_pc=0x3500 same cycle -> pc=0x3020.
- REQ-028 With PC_FETCH_CHECK_EN: redirect to 0x3002 -> fetch_exc=1; redirect to 0x7000 -> fetch_exc=1; to 0x3004 -> 0; without macro all 0.
- REQ-029 Stall held 70000 cycles -> stall_cnt saturates at 0xFFFF; reset -> 0.
